// File: rtl/truth_table_sweep.sv
// Exhaustive truth-table sweep engine: walks all 2^IN_W input vectors, captures the DUT
// response on the last hold cycle of each and folds it into a 16-bit MISR. Optional SWEEP_MISMATCH_EN.
module truth_table_sweep #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int HOLD  = 1,
    parameter int GRAY  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  vec_o,
    output logic             vec_valid_o,
    input  logic [OUT_W-1:0] resp_i,
`ifdef SWEEP_MISMATCH_EN
    input  logic [OUT_W-1:0] exp_i,
    output logic [IN_W:0]    err_cnt_o,
    output logic             err_o,
`endif
    output logic             cap_valid_o,
    output logic [IN_W-1:0]  cap_index_o,
    output logic [OUT_W-1:0] cap_data_o,
    output logic [15:0]      sig_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD - 1);
    localparam logic [IN_W-1:0] IDX_LAST  = {IN_W{1'b1}};

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t          state, state_next;
    logic [IN_W-1:0] idx, idx_next;
    logic [HC_W-1:0] hold_cnt, hold_cnt_next;
    logic            capture;
    logic            sweep_start;
    logic [15:0]     sig, sig_next, resp_ext;

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        hold_cnt_next = hold_cnt;
        capture       = 1'b0;
        sweep_start   = 1'b0;
        case (state)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_next    = DRIVE;
                    idx_next      = '0;
                    hold_cnt_next = '0;
                    sweep_start   = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    capture       = 1'b1;
                    hold_cnt_next = '0;
                    if (idx == IDX_LAST) state_next = DONE;
                    else                 idx_next   = idx + 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        resp_ext              = '0;
        resp_ext[OUT_W-1:0]   = resp_i;
        sig_next = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ resp_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Capture record and signature; sig holds its value between sweeps and after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_o <= 1'b0;
            cap_index_o <= '0;
            cap_data_o  <= '0;
            sig         <= '0;
        end else begin
            cap_valid_o <= capture;
            if (capture) begin
                cap_index_o <= idx;
                cap_data_o  <= resp_i;
                sig         <= sig_next;
            end else if (sweep_start) begin
                sig <= '0;
            end
        end
    end

`ifdef SWEEP_MISMATCH_EN
    localparam logic [IN_W:0] ERR_MAX = {1'b1, {IN_W{1'b0}}};
    logic mismatch;
    assign mismatch = capture && (resp_i != exp_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= mismatch;
            if (sweep_start)
                err_cnt_o <= '0;
            else if (mismatch && err_cnt_o != ERR_MAX)
                err_cnt_o <= err_cnt_o + 1'b1;
        end
    end
`endif

    always_comb begin
        vec_o = '0;
        if (state == DRIVE) vec_o = (GRAY != 0) ? (idx ^ (idx >> 1)) : idx;
    end

    assign vec_valid_o = (state == DRIVE);
    assign busy_o      = (state == DRIVE);
    assign done_o      = (state == DONE);
    assign sig_o       = sig;

endmodule
